first_one_decoder: RTL and testbench
====================================

# first_one_decoder

Receive-side counterpart of the first-one encoder: accepts a stream of encoded first-one codes over a valid/ready handshake and rebuilds the original bit mask, one word per `in_last`-terminated burst. Code `c` in 1..WIDTH marks bit `c-1`; code 0 means "no bit set". The block checks that codes within a word strictly ascend, which is what repeated find-first-and-clear produces. It flags illegal and out-of-order codes alongside each rebuilt word.

## Interface
- `WIDTH`, default 4: mask width; legal codes are 0..WIDTH.
- `CODE_W`, default `$clog2(WIDTH+1)` (3 for WIDTH=4): code and count width; derived, not overridden.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `in_valid` input, 1 bit: code beat valid.
- `in_ready` output, 1 bit: block can accept a beat.
- `in_code` input, CODE_W bits: encoded first-one code.
- `in_last` input, 1 bit: final beat of the current word.
- `out_valid` output, 1 bit: rebuilt word valid.
- `out_ready` input, 1 bit: consumer accepts the word.
- `out_mask` output, WIDTH bits: rebuilt mask.
- `out_count` output, CODE_W bits: number of legal nonzero codes in the word; saturates at all-ones.
- `out_err` output, 2 bits: [0] illegal code seen (code > WIDTH); [1] order violation seen.

## Operation
- States:
  - ACCUM: collecting beats; the reset state.
  - HOLD: word presented on the output.
- ACCUM:
  - `in_ready`=1 and `out_valid`=0.
  - Each accepted beat (`in_valid && in_ready`) updates the accumulators as follows:
    - Code 0: no mask, count or order effect.
    - Code 1..WIDTH: OR bit `code-1` into the mask and increment the count (saturating). If the code is ≤ the last nonzero code of this word, set `err[1]`; the bit is still ORed in, so a duplicate leaves the mask unchanged. Store the code as the last nonzero code.
    - Code > WIDTH: set `err[0]`; no mask, count or order effect.
  - A beat with `in_last`=1 updates the accumulators as above, copies them to the output registers, clears them, and moves to HOLD.
- HOLD:
  - `in_ready`=0.
  - `out_valid`=1; `out_mask`, `out_count` and `out_err` are stable until the handshake.
  - On `out_ready`=1: return to ACCUM and clear `out_valid`.
  - No input beat is accepted in the handshake cycle.
- A word consisting of a single code-0 beat with `in_last` yields mask 0, count 0, err 0.
- Reset (asynchronous, any time including mid-word or in HOLD):
  - State goes to ACCUM and the partial word is discarded.
  - `in_ready`=1 is the reset value seen after reset deasserts.
  - `out_valid`, `out_mask`, `out_count` and `out_err` are all 0.
  - Last-code register is 0.

## Timing
- `in_ready` is a registered-state decode (`state==ACCUM`) with no combinational path from `out_ready`.
- Latency: a last beat accepted at edge N gives `out_valid`=1 after edge N; it is visible in cycle N+1.
- Throughput: at most one word per (beats + 1) cycles. The HOLD cycle is mandatory even when `out_ready` is held high.
- `in_valid` held without `in_ready` stalls with no state change. Producers must hold `in_code` and `in_last` stable until accepted.
- Illegal code together with `in_last`: `err[0]` is set in that same word's output.
- Order check compares only against nonzero legal codes of the current word; the first legal code of a word never sets `err[1]`.

## Structure
- Shared package `first_one_pkg` holds:
  - `code_w(width)` function.
  - State enum {ACCUM, HOLD}.
  - Error bit index constants `ERR_ILLEGAL`=0 and `ERR_ORDER`=1.
  - `CODE_NONE`=0.
- Sub-module `code_to_onehot`: combinational; inputs code and WIDTH; outputs the one-hot mask and a `legal` flag. Code 0 gives mask 0 with legal=1; code > WIDTH gives legal=0.
- Top level holds the handshake FSM, the accumulators (mask, count, err, last code) and the output registers.

## Test plan
- WIDTH=4, beats 1, 3, 4(last) with `out_ready` high → `out_mask`=4'b1101, `out_count`=3, `out_err`=2'b00. `out_valid` rises the cycle after the last beat; `in_ready` is low for exactly one cycle.
- Single beat 0(last) → mask 4'b0000, count 0, err 2'b00. Then beat 2(last) → mask 4'b0010, count 1, proving the accumulators cleared between words.
- Beats 3, 2, 3(last) → mask 4'b0110, count 3, err 2'b10.
- Beats 6, 1(last) → mask 4'b0001, count 1, err 2'b01. Beat 7(last) → mask 0, count 0, err 2'b01.
- Hold `out_ready` low for 5 cycles after a word → `out_valid`=1 and `in_ready`=0 throughout, outputs stable, and a pending `in_valid` beat is not accepted until the cycle after `out_ready` rises.
- Assert `rst_n` low after beats 1, 2 (no last), then send beat 4(last) → mask 4'b1000, count 1. During reset all outputs are 0; after reset `in_ready`=1.

Source files
------------

// File: rtl/first_one_pkg.sv
// Shared types and constants for the first-one code decoder.
package first_one_pkg;

  function automatic int code_w(input int width);
    return $clog2(width + 1);
  endfunction

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_ORDER   = 1;
  localparam int CODE_NONE   = 0;

endpackage

// File: rtl/code_to_onehot.sv
// Maps a first-one code to its one-hot bit; code 0 is legal and empty,
// codes above WIDTH are flagged illegal.
module code_to_onehot #(
  parameter int WIDTH  = 4,
  parameter int CODE_W = 3
) (
  input  logic [CODE_W-1:0] code,
  output logic [WIDTH-1:0]  mask,
  output logic              legal
);

  always_comb begin
    mask  = '0;
    legal = (int'(code) <= WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (int'(code) == i + 1);
    end
  end

endmodule

// File: rtl/first_one_decoder.sv
// Rebuilds a bit mask from a burst of first-one codes and flags
// illegal or non-ascending codes alongside each word.
//
//   state | meaning
//   ACCUM | accepting code beats into the accumulators
//   HOLD  | rebuilt word presented, waiting for out_ready
module first_one_decoder
  import first_one_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CODE_W = code_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_mask,
  output logic [CODE_W-1:0] out_count,
  output logic [1:0]        out_err
);

  state_t state, state_nxt;

  logic [WIDTH-1:0]  acc_mask, nxt_mask, beat_mask;
  logic [CODE_W-1:0] acc_count, nxt_count;
  logic [CODE_W-1:0] last_code, nxt_last;
  logic [1:0]        acc_err, nxt_err;
  logic              beat_legal, beat_set, accept;

  code_to_onehot #(
    .WIDTH (WIDTH),
    .CODE_W(CODE_W)
  ) u_onehot (
    .code (in_code),
    .mask (beat_mask),
    .legal(beat_legal)
  );

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign beat_set  = beat_legal && (in_code != CODE_W'(CODE_NONE));

  // last_code == 0 means no bit yet, so the first legal code never trips the order check
  always_comb begin
    nxt_mask  = acc_mask | beat_mask;
    nxt_count = acc_count;
    nxt_last  = last_code;
    nxt_err   = acc_err;
    if (!beat_legal) begin
      nxt_err[ERR_ILLEGAL] = 1'b1;
    end
    if (beat_set) begin
      if (acc_count != '1) begin
        nxt_count = acc_count + CODE_W'(1);
      end
      if (in_code <= last_code) begin
        nxt_err[ERR_ORDER] = 1'b1;
      end
      nxt_last = in_code;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc_mask  <= '0;
      acc_count <= '0;
      acc_err   <= '0;
      last_code <= '0;
      out_mask  <= '0;
      out_count <= '0;
      out_err   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (in_last) begin
          out_mask  <= nxt_mask;
          out_count <= nxt_count;
          out_err   <= nxt_err;
          acc_mask  <= '0;
          acc_count <= '0;
          acc_err   <= '0;
          last_code <= '0;
        end else begin
          acc_mask  <= nxt_mask;
          acc_count <= nxt_count;
          acc_err   <= nxt_err;
          last_code <= nxt_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_first_one_decoder.sv
// Directed vector bench for first_one_decoder at WIDTH=4.
module tb_first_one_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_mask;
  logic [2:0] out_count;
  logic [1:0] out_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  first_one_decoder #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mask (out_mask),
    .out_count(out_count),
    .out_err  (out_err)
  );

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][2:0] codes;
    logic [3:0]      mask;
    logic [2:0]      cnt;
    logic [1:0]      err;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic [2:0] n, input logic [2:0] c0, input logic [2:0] c1,
                              input logic [2:0] c2, input logic [2:0] c3, input logic [3:0] mask,
                              input logic [2:0] cnt, input logic [1:0] err);
    vec_t v;
    v.n = n;
    v.codes[0] = c0;
    v.codes[1] = c1;
    v.codes[2] = c2;
    v.codes[3] = c3;
    v.mask = mask;
    v.cnt = cnt;
    v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_beat(input logic [2:0] code, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_code  = code;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = 3'd0;
    in_last  = 1'b0;
  endtask

  // Expects the word visible now, and drained after one more cycle with out_ready high.
  task automatic check_word(input string name, input logic [3:0] mask, input logic [2:0] cnt,
                            input logic [1:0] err);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_ready_low"}, 32'(in_ready), 32'd0);
    chk({name, "_mask"}, 32'(out_mask), 32'(mask));
    chk({name, "_count"}, 32'(out_count), 32'(cnt));
    chk({name, "_err"}, 32'(out_err), 32'(err));
    @(negedge clk);
    chk({name, "_drained"}, 32'(out_valid), 32'd0);
    chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = mk(3'd3, 3'd1, 3'd3, 3'd4, 3'd0, 4'b1101, 3'd3, 2'b00);
    vecs[1] = mk(3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 4'b0000, 3'd0, 2'b00);
    vecs[2] = mk(3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 4'b0010, 3'd1, 2'b00);
    vecs[3] = mk(3'd3, 3'd3, 3'd2, 3'd3, 3'd0, 4'b0110, 3'd3, 2'b10);
    vecs[4] = mk(3'd2, 3'd6, 3'd1, 3'd0, 3'd0, 4'b0001, 3'd1, 2'b01);
    vecs[5] = mk(3'd1, 3'd7, 3'd0, 3'd0, 3'd0, 4'b0000, 3'd0, 2'b01);
    vecs[6] = mk(3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 4'b1000, 3'd4, 2'b10);
    vecs[7] = mk(3'd4, 3'd0, 3'd1, 3'd0, 3'd2, 4'b0011, 3'd2, 2'b00);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mask", 32'(out_mask), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 8; v++) begin
      for (int b = 0; b < int'(vecs[v].n); b++) begin
        send_beat(vecs[v].codes[b], b == int'(vecs[v].n) - 1);
      end
      check_word($sformatf("vec%0d", v), vecs[v].mask, vecs[v].cnt, vecs[v].err);
    end

    // Nine legal codes: count saturates at 7, repeats flag order
    for (int b = 0; b < 9; b++) begin
      send_beat(3'((b % 4) + 1), b == 8);
    end
    check_word("saturate", 4'b1111, 3'd7, 2'b10);

    // Backpressure: word held for 5 cycles while a beat is pending
    out_ready = 1'b0;
    send_beat(3'd1, 1'b1);
    in_valid = 1'b1;
    in_code  = 3'd2;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d_mask", i), 32'(out_mask), 32'b0001);
      chk($sformatf("hold%0d_count", i), 32'(out_count), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_valid_low", 32'(out_valid), 32'd0);
    chk("hs_beat_not_taken", 32'(in_ready), 32'd1);
    chk("hs_mask_kept", 32'(out_mask), 32'b0001);
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = 3'd0;
    in_last  = 1'b0;
    check_word("pending", 4'b0010, 3'd1, 2'b00);

    // Reset mid-word discards the partial accumulators
    send_beat(3'd1, 1'b0);
    send_beat(3'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_mask", 32'(out_mask), 32'd0);
    chk("midrst_count", 32'(out_count), 32'd0);
    chk("midrst_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    send_beat(3'd4, 1'b1);
    check_word("after_rst", 4'b1000, 3'd1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
